// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard/sequencing bundle between the hazard controller and the pipeline.
//
// Signals
//   Pipeline status (driven by the pipeline, read by the controller):
//     id_rs, id_rt, id_uses_rs, id_uses_rt   ID-stage source registers and use flags
//     ex_rd, ex_regwrite, ex_memread         EX-stage destination / write / load
//     mem_rd, mem_regwrite                   EX/MEM destination / write
//     mem_branch, mem_zero                   EX/MEM branch and latched zero flag
//     dmem_req, dmem_ready                   data-memory access handshake
//   Controls (driven by the controller):
//     pc_en, ifid_en, idex_en, exmem_en      register advance enables
//     ifid_flush, idex_flush, exmem_flush    bubble-load requests
//     pc_sel                                 1 = branch target, 0 = PC+4
//     fwd_a, fwd_b                           EX operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
//     mem_err                                sticky memory timeout
//     stall_cnt, flush_cnt                   saturating event counters
//
// Modports: master = controller side, slave = pipeline side.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic             mem_branch;
  logic             mem_zero;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pc_sel;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, mem_branch, mem_zero, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush,
    output pc_sel, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, mem_branch, mem_zero, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush,
    input  pc_sel, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage processor.
//
// Decides each cycle whether IF/ID, ID/EX and EX/MEM advance, freeze or are squashed, and
// selects the PC source. Handles memory waits (with timeout to HALT), taken branches
// resolved in EX/MEM, RAW/load-use stalls and registered EX operand forwarding.
//
// Ports
//   clk   pipeline clock, rising edge
//   rst   synchronous reset, active-high (forces all enables 0 and all flushes 1)
//   bus   hazard_ctrl_if.master: pipeline status in, enables/flushes/pc_sel/fwd/counters out
//
// Parameters
//   MEM_TIMEOUT  consecutive waiting cycles before the controller halts
//   CNT_W        width of the saturating stall/flush counters (must match the interface)
//
// Build option
//   FORWARDING_EN  defined: forwarding active, only load-use stalls.
//                  undefined: fwd_* tied to 00, stall on any match with a writing EX or MEM
//                  destination (up to two bubbles).
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.master bus
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  state_e           state_q;
  logic [WaitW-1:0] wait_q;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic             mem_wait, branch_taken, raw_stall, resolve;
  logic             take_branch, take_stall;
  logic             ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic [1:0]       fwd_a_c, fwd_b_c;
  logic [WaitW-1:0] wait_inc;

  assign mem_wait     = bus.dmem_req & ~bus.dmem_ready;
  assign branch_taken = bus.mem_branch & bus.mem_zero;
  assign wait_inc     = wait_q + WaitW'(1);

  // Register 0 never matches: every hit requires a nonzero destination.
  assign ex_rs_hit  = bus.id_uses_rs & (bus.ex_rd != 5'd0) & (bus.id_rs == bus.ex_rd);
  assign ex_rt_hit  = bus.id_uses_rt & (bus.ex_rd != 5'd0) & (bus.id_rt == bus.ex_rd);
  assign mem_rs_hit = bus.id_uses_rs & (bus.mem_rd != 5'd0) & (bus.id_rs == bus.mem_rd);
  assign mem_rt_hit = bus.id_uses_rt & (bus.mem_rd != 5'd0) & (bus.id_rt == bus.mem_rd);

`ifdef FORWARDING_EN
  assign raw_stall = bus.ex_memread & (ex_rs_hit | ex_rt_hit);

  // Forward selects ignore the use flags: an unused operand's select is harmless.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (bus.ex_regwrite & (bus.ex_rd != 5'd0) & (bus.ex_rd == bus.id_rs)) begin
      fwd_a_c = 2'b10;
    end else if (bus.mem_regwrite & (bus.mem_rd != 5'd0) & (bus.mem_rd == bus.id_rs)) begin
      fwd_a_c = 2'b01;
    end
    if (bus.ex_regwrite & (bus.ex_rd != 5'd0) & (bus.ex_rd == bus.id_rt)) begin
      fwd_b_c = 2'b10;
    end else if (bus.mem_regwrite & (bus.mem_rd != 5'd0) & (bus.mem_rd == bus.id_rt)) begin
      fwd_b_c = 2'b01;
    end
  end
`else
  // Without forwarding, wait until the producer reaches WB (write-before-read RF).
  assign raw_stall = ((bus.ex_regwrite | bus.ex_memread) & (ex_rs_hit | ex_rt_hit)) |
                     (bus.mem_regwrite & (mem_rs_hit | mem_rt_hit));
  assign fwd_a_c   = 2'b00;
  assign fwd_b_c   = 2'b00;
`endif

  // Zero-latency pipeline control.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.idex_en     = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.pc_sel      = 1'b0;
    take_branch     = 1'b0;
    take_stall      = 1'b0;

    // resolve: the pipeline may move this cycle (a held branch fires when ready arrives).
    unique case (state_q)
      StRun:     resolve = ~mem_wait;
      StMemWait: resolve = bus.dmem_ready;
      StHalt:    resolve = 1'b0;
      default:   resolve = 1'b0;
    endcase

    if (rst) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else if (resolve) begin
      if (branch_taken) begin
        // Squashes any stalled ID instruction too, so no stall is counted.
        take_branch     = 1'b1;
        bus.pc_sel      = 1'b1;
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
      end else if (raw_stall) begin
        take_stall     = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.idex_flush = 1'b1;
      end else begin
        bus.pc_en    = 1'b1;
        bus.ifid_en  = 1'b1;
        bus.idex_en  = 1'b1;
        bus.exmem_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_q      <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_wait) begin
            state_q <= StMemWait;
            wait_q  <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (bus.dmem_ready) begin
            state_q <= StRun;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_inc;
            if (wait_inc >= TimeoutVal) begin
              state_q   <= StHalt;
              mem_err_q <= 1'b1;
            end
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StRun;
      endcase

      if (take_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (take_branch && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end

      if (bus.idex_flush) begin
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else if (bus.idex_en) begin
        fwd_a_q <= fwd_a_c;
        fwd_b_q <= fwd_b_c;
      end
    end
  end

  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int unsigned CW = 4;

  // ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, pc_sel}
  localparam logic [7:0] CTL_RST   = 8'b0000_1110;
  localparam logic [7:0] CTL_RUN   = 8'b1111_0000;
  localparam logic [7:0] CTL_WAIT  = 8'b0000_0000;
  localparam logic [7:0] CTL_BR    = 8'b1111_1111;
  localparam logic [7:0] CTL_STALL = 8'b0011_0100;

`ifdef FORWARDING_EN
  localparam int STALL_LU  = 1;
  localparam int STALL_TOT = 1;
`else
  localparam int STALL_LU  = 2;
  localparam int STALL_TOT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.pc_sel};

  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs = 5'd0;  bus.id_rt = 5'd0;  bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
    bus.ex_rd = 5'd0;  bus.ex_regwrite = 1'b0;  bus.ex_memread = 1'b0;
    bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.mem_branch = 1'b0; bus.mem_zero = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_r5();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1; bus.id_rt = 5'd7;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RST) begin n_fail++; $display("FAIL reset_ctl: got %b exp %b", ctl, CTL_RST); end
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b exp 00", bus.fwd_a); end
    n_chk++;
    if (bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b exp 00", bus.fwd_b); end
    n_chk++;
    if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b exp 0", bus.mem_err); end
    n_chk++;
    if (bus.stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", bus.stall_cnt);
    end
    n_chk++;
    if (bus.flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_flush_cnt: got %0d exp 0", bus.flush_cnt);
    end
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL reset_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    load_use_r5();
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL lu_stall: got %b exp %b", ctl, CTL_STALL); end
    tick();
    // load advances to MEM, bubble in EX, same instruction still in ID
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0;
    bus.mem_rd = 5'd5; bus.mem_regwrite = 1'b1;
`ifdef FORWARDING_EN
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_release: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b01) begin n_fail++; $display("FAIL lu_fwd_a: got %b exp 01", bus.fwd_a); end
`else
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL lu_stall2: got %b exp %b", ctl, CTL_STALL); end
    tick();
    bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_release: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_a: got %b exp 00", bus.fwd_a); end
`endif
    n_chk++;
    if (bus.stall_cnt !== 4'(STALL_LU)) begin
      n_fail++; $display("FAIL lu_stall_cnt: got %0d exp %0d", bus.stall_cnt, STALL_LU);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.ex_regwrite = 1'b1;  bus.ex_rd = 5'd3;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd4;
    bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
`ifdef FORWARDING_EN
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL b2b_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b10) begin n_fail++; $display("FAIL b2b_fwd_a: got %b exp 10", bus.fwd_a); end
    n_chk++;
    if (bus.fwd_b !== 2'b01) begin n_fail++; $display("FAIL b2b_fwd_b: got %b exp 01", bus.fwd_b); end
    // EX/MEM result wins over MEM/WB when both write the same register
    bus.ex_rd = 5'd6; bus.mem_rd = 5'd6; bus.id_rs = 5'd6; bus.id_rt = 5'd6;
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b10) begin n_fail++; $display("FAIL prio_fwd_a: got %b exp 10", bus.fwd_a); end
    n_chk++;
    if (bus.fwd_b !== 2'b10) begin n_fail++; $display("FAIL prio_fwd_b: got %b exp 10", bus.fwd_b); end
`else
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL b2b_stall1: got %b exp %b", ctl, CTL_STALL); end
    tick();
    bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0; bus.mem_rd = 5'd3;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL b2b_stall2: got %b exp %b", ctl, CTL_STALL); end
    tick();
    bus.mem_regwrite = 1'b0; bus.mem_rd = 5'd0;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL b2b_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd_a: got %b exp 00", bus.fwd_a); end
`endif
    n_chk++;
    if (bus.stall_cnt !== 4'(STALL_TOT)) begin
      n_fail++; $display("FAIL b2b_stall_cnt: got %0d exp %0d", bus.stall_cnt, STALL_TOT);
    end
  endtask

  task automatic test_branch();
    idle();
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_BR) begin n_fail++; $display("FAIL br_taken: got %b exp %b", ctl, CTL_BR); end
    tick();
    n_chk++;
    if (bus.flush_cnt !== 4'd1) begin n_fail++; $display("FAIL br_cnt: got %0d exp 1", bus.flush_cnt); end
    n_chk++;
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL br_fwd_clr: got %b exp 00", bus.fwd_a); end
    bus.mem_branch = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL br_one_cycle: got %b exp %b", ctl, CTL_RUN); end
    tick();
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL br_not_taken: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.flush_cnt !== 4'd1) begin n_fail++; $display("FAIL br_nt_cnt: got %0d exp 1", bus.flush_cnt); end
    // branch and load-use together: flush only
    bus.mem_zero = 1'b1;
    load_use_r5();
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_BR) begin n_fail++; $display("FAIL br_lu: got %b exp %b", ctl, CTL_BR); end
    tick();
    n_chk++;
    if (bus.flush_cnt !== 4'd2) begin n_fail++; $display("FAIL br_lu_fcnt: got %0d exp 2", bus.flush_cnt); end
    n_chk++;
    if (bus.stall_cnt !== 4'(STALL_TOT)) begin
      n_fail++; $display("FAIL br_lu_scnt: got %0d exp %0d", bus.stall_cnt, STALL_TOT);
    end
  endtask

  task automatic test_mem_wait();
    idle();
    bus.dmem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (ctl !== CTL_WAIT) begin
        n_fail++; $display("FAIL mw_hold%0d: got %b exp %b", i, ctl, CTL_WAIT);
      end
      tick();
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL mw_resume: got %b exp %b", ctl, CTL_RUN); end
    tick();
    idle();
    n_chk++;
    if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL mw_err: got %b exp 0", bus.mem_err); end
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL mw_back_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
  endtask

  task automatic test_branch_wait();
    idle();
    bus.dmem_req = 1'b1; bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL bw_hold: got %b exp %b", ctl, CTL_WAIT); end
    tick();
    tick();
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_BR) begin n_fail++; $display("FAIL bw_fire: got %b exp %b", ctl, CTL_BR); end
    tick();
    idle();
    n_chk++;
    if (bus.flush_cnt !== 4'd3) begin n_fail++; $display("FAIL bw_cnt: got %0d exp 3", bus.flush_cnt); end
  endtask

  task automatic test_timeout();
    idle();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_chk++;
    if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b exp 0", bus.mem_err); end
    tick();
    n_chk++;
    if (bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b exp 1", bus.mem_err); end
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL halt_hold: got %b exp %b", ctl, CTL_WAIT); end
    tick();
    n_chk++;
    if (bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b exp 1", bus.mem_err); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RST) begin n_fail++; $display("FAIL halt_rst_ctl: got %b exp %b", ctl, CTL_RST); end
    tick();
    rst = 1'b0;
    idle();
    n_chk++;
    if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL halt_rst_err: got %b exp 0", bus.mem_err); end
    n_chk++;
    if (bus.flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL halt_rst_fcnt: got %0d exp 0", bus.flush_cnt);
    end
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL halt_rst_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd0;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0;
    bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL r0_run: got %b exp %b", ctl, CTL_RUN); end
    tick();
    n_chk++;
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL r0_fwd_a: got %b exp 00", bus.fwd_a); end
    n_chk++;
    if (bus.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL r0_scnt: got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_saturate();
    idle();
    load_use_r5();
    for (int i = 0; i < 20; i++) tick();
    n_chk++;
    if (bus.stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_stall: got %0d exp 15", bus.stall_cnt);
    end
    idle();
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_chk++;
    if (bus.flush_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_flush: got %0d exp 15", bus.flush_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_mem_wait();
    test_branch_wait();
    test_timeout();
    test_zero_reg();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
